// File: rtl/mipi_tx_pixel_packer.sv
// RGB888 parallel pixels to 32-bit little-endian payload words.
// One FIFO-ready line request per line, with overflow and line-length flags.
module mipi_tx_pixel_packer #(
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned LINE_WORDS = H_ACTIVE * 3 / 4
) (
  input  logic        clk_periph,
  input  logic        rstn,
  input  logic        rx_vsync,
  input  logic        rx_hsync,
  input  logic        rx_de,
  input  logic [23:0] rx_pixel,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  output logic        frame_start,
  output logic        tx_fifo_req,
  output logic [10:0] line_word_cnt,
  output logic        ovf_err,
  output logic        len_err
);

  // Pixel counter saturates above H_ACTIVE so overlong lines never alias.
  localparam int unsigned CNT_MAX =
    (H_ACTIVE > LINE_WORDS) ? H_ACTIVE + 1 : LINE_WORDS + 1;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        vs_q;
  logic [1:0]  phase_q, phase_d;
  logic [23:0] res_q, res_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] data_q, data_d;
  logic        fs_q, fs_d;
  logic        req_q, req_d;
  logic [10:0] wcnt_q, wcnt_d;
  logic        ovf_q, ovf_d;
  logic        len_q, len_d;

  logic        vs_rise;
  logic        wr_try;
  logic [31:0] word;
  logic        hsync_unused;

  assign hsync_unused = rx_hsync;
  assign vs_rise      = rx_vsync & ~vs_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    res_d   = res_q;
    pix_d   = pix_q;
    wr_en_d = 1'b0;
    data_d  = data_q;
    fs_d    = 1'b0;
    req_d   = 1'b0;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    len_d   = len_q;
    wr_try  = 1'b0;
    word    = 32'h0;
    if (vs_rise) begin
      state_d = S_WAIT;
      fs_d    = 1'b1;
      ovf_d   = 1'b0;
      len_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (rx_de) begin
            state_d = S_ACTIVE;
            phase_d = 2'd1;
            res_d   = rx_pixel;
            pix_d   = CNT_W'(1);
            wcnt_d  = 11'd0;
          end
        end
        S_ACTIVE: begin
          if (rx_de) begin
            if (pix_q != CNT_W'(CNT_MAX))
              pix_d = pix_q + CNT_W'(1);
            phase_d = phase_q + 2'd1;
            unique case (phase_q)
              2'd0: res_d = rx_pixel;
              2'd1: begin
                word   = {rx_pixel[7:0], res_q};
                res_d  = {8'h0, rx_pixel[23:8]};
                wr_try = 1'b1;
              end
              2'd2: begin
                word   = {rx_pixel[15:0], res_q[15:0]};
                res_d  = {16'h0, rx_pixel[23:16]};
                wr_try = 1'b1;
              end
              default: begin
                word   = {rx_pixel, res_q[7:0]};
                res_d  = 24'h0;
                wr_try = 1'b1;
              end
            endcase
          end else begin
            if (pix_q != CNT_W'(H_ACTIVE))
              len_d = 1'b1;
            state_d = (phase_q != 2'd0) ? S_FLUSH : S_DONE;
          end
        end
        S_FLUSH: begin
          word    = {8'h0, res_q};
          wr_try  = 1'b1;
          res_d   = 24'h0;
          phase_d = 2'd0;
          state_d = S_DONE;
        end
        S_DONE: begin
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (wr_try) begin
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d = 1'b1;
        data_d  = word;
        if (wcnt_q != 11'h7FF)
          wcnt_d = wcnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_periph) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b0;
      phase_q <= 2'd0;
      res_q   <= 24'h0;
      pix_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= 32'h0;
      fs_q    <= 1'b0;
      req_q   <= 1'b0;
      wcnt_q  <= 11'd0;
      ovf_q   <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= rx_vsync;
      phase_q <= phase_d;
      res_q   <= res_d;
      pix_q   <= pix_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
      req_q   <= req_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      len_q   <= len_d;
    end
  end

  assign fifo_wr_en    = wr_en_q;
  assign fifo_wr_data  = data_q;
  assign frame_start   = fs_q;
  assign tx_fifo_req   = req_q;
  assign line_word_cnt = wcnt_q;
  assign ovf_err       = ovf_q;
  assign len_err       = len_q;

endmodule

// File: tb/tb_mipi_tx_pixel_packer.sv
// Directed bench for mipi_tx_pixel_packer with H_ACTIVE=4.
// Pixel k carries bytes 3k+1..3k+3, so payload bytes count up from 1.
module tb_mipi_tx_pixel_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_vsync = 1'b0;
  logic        rx_hsync = 1'b0;
  logic        rx_de = 1'b0;
  logic [23:0] rx_pixel = 24'h0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        frame_start;
  logic        tx_fifo_req;
  logic [10:0] line_word_cnt;
  logic        ovf_err;
  logic        len_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] wq[$];
  int n_req = 0;
  int n_fs = 0;
  int req0, fs0;

  mipi_tx_pixel_packer #(.H_ACTIVE(4), .LINE_WORDS(3)) dut (
    .clk_periph   (clk),
    .rstn         (rstn),
    .rx_vsync     (rx_vsync),
    .rx_hsync     (rx_hsync),
    .rx_de        (rx_de),
    .rx_pixel     (rx_pixel),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .frame_start  (frame_start),
    .tx_fifo_req  (tx_fifo_req),
    .line_word_cnt(line_word_cnt),
    .ovf_err      (ovf_err),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr_en) wq.push_back(fifo_wr_data);
    if (tx_fifo_req) n_req++;
    if (frame_start) n_fs++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pix(input int k);
    logic [7:0] b0, b1, b2;
    b0 = 8'(3 * k + 1);
    b1 = 8'(3 * k + 2);
    b2 = 8'(3 * k + 3);
    return {b2, b1, b0};
  endfunction

  // Expected word w of an n-pixel line: byte b is b+1, zero past the end.
  function automatic logic [31:0] exp_word(input int n, input int w);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++)
      if (4 * w + i < 3 * n) r[8*i +: 8] = 8'(4 * w + i + 1);
    return r;
  endfunction

  task automatic send_line(input int n, input logic [7:0] fmask);
    rx_hsync = 1'b1;
    tick();
    rx_hsync = 1'b0;
    for (int k = 0; k < n; k++) begin
      rx_de     = 1'b1;
      rx_pixel  = pix(k);
      fifo_full = (k < 8) ? fmask[k] : 1'b0;
      tick();
    end
    rx_de     = 1'b0;
    rx_pixel  = 24'h0;
    fifo_full = 1'b0;
    repeat (6) tick();
  endtask

  task automatic vsync();
    rx_vsync = 1'b1;
    tick();
    tick();
    rx_vsync = 1'b0;
    tick();
  endtask

  task automatic chk_line(input string tag, input int n, input int nw);
    chk({tag, "_nwords"}, 32'(wq.size()), 32'(nw));
    for (int w = 0; w < nw && w < wq.size(); w++)
      chk({tag, "_word"}, wq[w], exp_word(n, w));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'h0);
    chk({tag, "_data"}, fifo_wr_data, 32'h0);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
    chk({tag, "_req"}, 32'(tx_fifo_req), 32'h0);
    chk({tag, "_cnt"}, 32'(line_word_cnt), 32'h0);
    chk({tag, "_ovf"}, 32'(ovf_err), 32'h0);
    chk({tag, "_len"}, 32'(len_err), 32'h0);
  endtask

  initial begin
    repeat (2) tick();
    chk_zero("reset");
    rstn = 1'b1;
    tick();

    // No frame sync yet: pixels must be ignored.
    wq.delete();
    send_line(4, 8'h0);
    chk("pre_vsync_writes", 32'(wq.size()), 32'h0);
    chk("pre_vsync_req", 32'(n_req), 32'h0);

    vsync();
    chk("frame_start_1", 32'(n_fs), 32'd1);

    // Exact line of 4 pixels.
    wq.delete();
    req0 = n_req;
    send_line(4, 8'h0);
    chk_line("line4", 4, 3);
    chk("line4_w0", wq.size() > 0 ? wq[0] : 32'hx, 32'h04030201);
    chk("line4_w2", wq.size() > 2 ? wq[2] : 32'hx, 32'h0C0B0A09);
    chk("line4_req", 32'(n_req - req0), 32'd1);
    chk("line4_cnt", 32'(line_word_cnt), 32'd3);
    chk("line4_len", 32'(len_err), 32'h0);

    // Overlong line of 5 pixels: flush word and length error.
    wq.delete();
    req0 = n_req;
    send_line(5, 8'h0);
    chk_line("line5", 5, 4);
    chk("line5_last", wq.size() > 3 ? wq[3] : 32'hx, 32'h000F0E0D);
    chk("line5_req", 32'(n_req - req0), 32'd1);
    chk("line5_cnt", 32'(line_word_cnt), 32'd4);
    chk("line5_len", 32'(len_err), 32'h1);
    vsync();
    chk("len_cleared", 32'(len_err), 32'h0);

    // Short line of 2 pixels: flush of two residual bytes.
    wq.delete();
    send_line(2, 8'h0);
    chk_line("line2", 2, 2);
    chk("line2_last", wq.size() > 1 ? wq[1] : 32'hx, 32'h00000605);
    chk("line2_len", 32'(len_err), 32'h1);
    vsync();

    // FIFO full during pixels 2 and 3: two words dropped.
    wq.delete();
    req0 = n_req;
    send_line(4, 8'b0110);
    chk("ovf_nwords", 32'(wq.size()), 32'd1);
    chk("ovf_word", wq.size() > 0 ? wq[0] : 32'hx, 32'h0C0B0A09);
    chk("ovf_cnt", 32'(line_word_cnt), 32'd1);
    chk("ovf_flag", 32'(ovf_err), 32'h1);
    chk("ovf_req", 32'(n_req - req0), 32'd1);
    vsync();
    chk("ovf_cleared", 32'(ovf_err), 32'h0);

    // vsync rising mid-line after 2 pixels aborts the line.
    wq.delete();
    req0 = n_req;
    fs0 = n_fs;
    for (int k = 0; k < 2; k++) begin
      rx_de    = 1'b1;
      rx_pixel = pix(k);
      tick();
    end
    rx_de    = 1'b0;
    rx_vsync = 1'b1;
    tick();
    tick();
    rx_vsync = 1'b0;
    repeat (6) tick();
    chk("abort_nwords", 32'(wq.size()), 32'd1);
    chk("abort_req", 32'(n_req - req0), 32'd0);
    chk("abort_fs", 32'(n_fs - fs0), 32'd1);
    wq.delete();
    send_line(4, 8'h0);
    chk_line("after_abort", 4, 3);

    // Reset for one cycle mid-line.
    wq.delete();
    for (int k = 0; k < 2; k++) begin
      rx_de    = 1'b1;
      rx_pixel = pix(k);
      tick();
    end
    rx_de = 1'b0;
    rstn  = 1'b0;
    tick();
    chk_zero("midreset");
    rstn = 1'b1;
    tick();
    chk("midreset_wr_en", 32'(fifo_wr_en), 32'h0);
    wq.delete();
    req0 = n_req;
    send_line(4, 8'h0);
    chk("midreset_writes", 32'(wq.size()), 32'h0);
    chk("midreset_req", 32'(n_req - req0), 32'h0);

    // Small frame of 3 lines.
    fs0 = n_fs;
    vsync();
    wq.delete();
    req0 = n_req;
    for (int l = 0; l < 3; l++) send_line(4, 8'h0);
    chk("frame_words", 32'(wq.size()), 32'd9);
    for (int w = 0; w < 9 && w < wq.size(); w++)
      chk("frame_word", wq[w], exp_word(4, w % 3));
    chk("frame_req", 32'(n_req - req0), 32'd3);
    chk("frame_fs", 32'(n_fs - fs0), 32'd1);
    chk("frame_ovf", 32'(ovf_err), 32'h0);
    chk("frame_len", 32'(len_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mipi_tx_pixel_packer.md
MIPI_TX_PIXEL_PACKER -- requirements
Module: mipi_tx_pixel_packer

Interface
REQ-001 Parameter H_ACTIVE, default 1920, active pixels per line.
REQ-002 Parameter LINE_WORDS, default H_ACTIVE*3/4 (1440), expected 32-bit words per line.
REQ-003 clk_periph  input  1  sole clock; all logic on its rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 rx_vsync  input  1  frame sync from the RX parallel interface, active-high.
REQ-006 rx_hsync  input  1  line sync, active-high.
REQ-007 rx_de  input  1  pixel valid.
REQ-008 rx_pixel  input  24  RGB888 pixel: [7:0] byte0, [15:8] byte1, [23:16] byte2.
REQ-009 fifo_full  input  1  TX payload FIFO full.
REQ-010 fifo_wr_en  output  1  FIFO write strobe.
REQ-011 fifo_wr_data  output  32  packed payload word; byte0 in [7:0].
REQ-012 frame_start  output  1  one-cycle pulse at frame start.
REQ-013 tx_fifo_req  output  1  one-cycle pulse when a complete line is in the FIFO.
REQ-014 line_word_cnt  output  11  words written in current line.
REQ-015 ovf_err  output  1  sticky FIFO-overflow flag.
REQ-016 len_err  output  1  sticky line-length-mismatch flag.

Function
REQ-017 Packing: byte stream p0b0,p0b1,p0b2,p1b0,... packed little-endian into 32-bit words; 4 pixels yield 3 words.
REQ-018 Phase counter 0..3 increments per rx_de cycle, wraps 3->0; 24-bit residual register holds unemitted bytes.
REQ-019 Phase0: residual<=pixel, no write; phase1: write {p1[7:0],res[23:0]}, residual<=p1[23:8]; phase2: write {p2[15:0],res[15:0]}, residual<=p2[23:16]; phase3: write {p3,res[7:0]}, residual cleared.
REQ-020 Write latency: fifo_wr_en/fifo_wr_data registered, asserted the cycle after the completing pixel is sampled.
REQ-021 FSM states: IDLE, WAIT_LINE, ACTIVE, FLUSH, DONE.
REQ-022 IDLE -> WAIT_LINE on rx_vsync rising edge; frame_start pulses the cycle after that edge.
REQ-023 WAIT_LINE -> ACTIVE on first rx_de high; phase, residual, pixel count, line_word_cnt cleared on entry to ACTIVE.
REQ-024 ACTIVE -> FLUSH on rx_de falling edge when phase != 0; ACTIVE -> DONE when phase == 0.
REQ-025 FLUSH: one write of residual zero-padded in upper bytes, then -> DONE.
REQ-026 DONE: tx_fifo_req pulses one cycle, then -> WAIT_LINE.
REQ-027 rx_vsync rising edge in any state: abort current line, no flush, no tx_fifo_req, -> WAIT_LINE, frame_start pulse.
REQ-028 line_word_cnt increments per accepted write, saturates at 2047.
REQ-029 Pixel count at rx_de fall != H_ACTIVE: len_err set; line still flushed and tx_fifo_req still issued.
REQ-030 Write attempted with fifo_full high: word dropped (fifo_wr_en low), ovf_err set, line_word_cnt not incremented.
REQ-031 ovf_err and len_err cleared only by reset or rx_vsync rising edge.
REQ-032 rx_hsync only qualifies nothing; pixels outside rx_de ignored.

Reset
REQ-033 rstn low at a clock edge: FSM=IDLE, all outputs 0, fifo_wr_data 0, phase/residual/counters 0.
REQ-034 Reset mid-line discards partial data; no write or pulse in the cycle after reset release.
REQ-035 Before first rx_vsync rising edge after reset, rx_de activity produces no writes.

Verification
REQ-036 H_ACTIVE=4, pixels 0x030201,0x060504,0x090807,0x0C0B0A -> words 0x04030201,0x08070605,0x0C0B0A09, then one tx_fifo_req pulse, line_word_cnt=3.
REQ-037 H_ACTIVE=1920 full frame, 1080 lines -> 1440 writes per line, 1080 tx_fifo_req pulses, one frame_start, errors 0.
REQ-038 Line of 5 pixels (H_ACTIVE=4) -> 4 words, last word {8'h00, pixel5}, len_err=1, tx_fifo_req pulses.
REQ-039 fifo_full held high for 2 write cycles -> 2 words dropped, ovf_err=1, line_word_cnt=LINE_WORDS-2; next rx_vsync clears ovf_err.
REQ-040 rx_vsync rising mid-line after 2 pixels -> no flush write, no tx_fifo_req, frame_start pulse, next line packs from phase 0.
REQ-041 rstn low for 1 cycle mid-line -> all outputs 0 next cycle; no writes until rx_vsync rising edge.
